issue_queue: RTL and testbench
==============================

// Module: issue_queue
// PURPOSE
//  Issue stage directly downstream of decode/dispatch. Buffers renamed µops in IQ_LEN slots and tracks
//  source readiness via CDB wakeup. Each cycle selects the oldest ready µop whose FU is free and issues
//  it to execute. Supports selective flush of µops younger than a mispredicted branch.
// PARAMETERS
//  IQ_LEN   16        slot count; power of 2
//  ROB_LEN  `ROB_LEN  ROB depth; rob_idx width RW=$clog2(ROB_LEN)
//  LQW/SQW  $clog2(`LQ_LEN)+1 / $clog2(`SQ_LEN)+1   LSU tail widths
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset, synchronous, active-high
//  DC_valid       in   1     dispatch µop valid; already qualified by IS_ready
//  DC_out_*       in   -     pc32 inst32 imm32 op5 f3 f7 P_rs1/P_rs2/P_rd 7 fu_sel3 rob_idx RW LQ/SQ_tail jump1
//  rs1_rdy_in     in   1     busy-table lookup of DC_out_P_rs1 (1 = value available)
//  rs2_rdy_in     in   1     same, for DC_out_P_rs2
//  IS_ready       out  1     >=1 free slot; function of registered state only
//  cdb_valid      in   2     writeback lanes valid
//  cdb_P_rd       in   2x7   writeback physical tags
//  fu_ready       in   8     per-FU accept, indexed by fu_sel (0 alu … 7 store)
//  rob_head       in   RW    oldest ROB entry; age reference
//  mispredict     in   1     flush request
//  flush_rob_idx  in   RW    mispredicted branch; strictly younger entries die
//  stall          in   1     freeze selection
//  iss_valid      out  1     issue bundle valid, registered
//  iss_*          out  -     same field set as DC_out_*, registered
// BEHAVIOUR
//  Reset: all slot valid bits 0; iss_valid=0; all iss_* = 0; IS_ready=1.
//  Entry: valid, fields, r1, r2. use_rs1=0 for LUI/AUIPC/JAL; use_rs2=1 only for R_TYPE, F_TYPE,
//   S_TYPE, FSTORE, B_TYPE. Unused source: ready forced 1.
//  Allocate: DC_valid -> lowest free slot written at the edge. r1 = rs1_rdy_in | CDB hit on P_rs1 in
//   the same cycle | !use_rs1 (r2 likewise).
//  Wakeup: each cdb lane with cdb_valid and tag!=0 sets r1/r2 in every valid entry whose tag matches.
//   Tag 0 is always ready.
//  Age: age(i) = (rob_idx - rob_head) mod ROB_LEN; smaller = older. Unique, so ties cannot occur.
//  Select, combinational: candidate = valid & r1 & r2 & fu_ready[fu_sel]. Pick the minimum age.
//  Issue: if a candidate exists and !stall & !mispredict, the chosen slot is freed at the edge.
//   Its fields load iss_*; iss_valid=1 for exactly that cycle. Otherwise iss_valid<=0 and iss_* hold.
//  Latency: dispatch at edge t, sources ready -> earliest iss_valid at cycle t+1 (output of edge t+1).
//   Wakeup at edge t -> earliest issue register load at edge t+1. No same-cycle wakeup->select.
//  IS_ready = !(all slots valid). A slot freed in the same cycle is not counted (no bypass).
//   Full + DC_valid cannot occur; assertion checks it.
//  mispredict: at the edge, clear every slot with age > age(flush_rob_idx).
//   iss_valid<=0. No selection. Incoming DC_valid is ignored (DC already gates it).
//   Wakeups to surviving slots are still applied.
//  stall: no selection; iss_valid<=0; allocation and wakeup continue.
//  Wrap-around: rob_idx wraps mod ROB_LEN; age math is RW bits unsigned.
//  rst mid-operation: all state cleared on the next edge; other inputs ignored.
// STRUCTURE
//  ooo_pkg: opcode constants (R_TYPE, LOAD, ...), FU_* enum for fu_sel, typedef iq_entry_t,
//   typedef iss_bundle_t. Shared with the decode and execute stages.
//  Sub-module iq_select: inputs are the candidate vector and per-slot ages; outputs are grant valid
//   plus one-hot/index. Implemented as a combinational min-age tree.
//  Top level holds the slot array, wakeup CAM, free-slot priority encoder and output register.
// TESTING
//  T1 rst; DC ADD rob 3, rs1/rs2 ready, fu_ready=FF -> iss_valid=1 one cycle later, iss_rob_idx=3; IS_ready=1.
//  T2 ADD with P_rs1=40 not ready -> no issue; cdb P_rd=40 -> iss_valid on the next cycle, not the same one.
//  T3 head=30; ready rob 31 and rob 1 (wrapped), fu_ready=FF -> rob 31 issues first, then rob 1.
//  T4 fill 16 unready MULs -> IS_ready=0; fu_ready[1]=0 with all woken -> no issue; fu_ready[1]=1 -> one per cycle.
//  T5 head=0; entries rob 2,5,9; mispredict flush_rob_idx=5 -> 9 removed; 2 and 5 survive and issue.
//  T6 dispatch P_rs1=55 while cdb P_rd=55 same cycle -> r1 set at allocation; issues next cycle.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: opcode groups, functional-unit select codes, issue-queue entry layout.
// Used by the decode, issue and execute stages.
package ooo_pkg;

    localparam int ROB_LEN = 32;
    localparam int RW      = $clog2(ROB_LEN);
    localparam int LQ_LEN  = 16;
    localparam int SQ_LEN  = 16;
    localparam int LQW     = $clog2(LQ_LEN) + 1;
    localparam int SQW     = $clog2(SQ_LEN) + 1;
    localparam int PW      = 7;

    // Major opcode groups, inst[6:2]
    localparam logic [4:0] LOAD   = 5'b00000;
    localparam logic [4:0] FLOAD  = 5'b00001;
    localparam logic [4:0] I_TYPE = 5'b00100;
    localparam logic [4:0] AUIPC  = 5'b00101;
    localparam logic [4:0] S_TYPE = 5'b01000;
    localparam logic [4:0] FSTORE = 5'b01001;
    localparam logic [4:0] R_TYPE = 5'b01100;
    localparam logic [4:0] LUI    = 5'b01101;
    localparam logic [4:0] F_TYPE = 5'b10100;
    localparam logic [4:0] B_TYPE = 5'b11000;
    localparam logic [4:0] JALR   = 5'b11001;
    localparam logic [4:0] JAL    = 5'b11011;
    localparam logic [4:0] SYSTEM = 5'b11100;

    typedef enum logic [2:0] {
        FU_ALU   = 3'd0,
        FU_MUL   = 3'd1,
        FU_DIV   = 3'd2,
        FU_BR    = 3'd3,
        FU_FPU   = 3'd4,
        FU_CSR   = 3'd5,
        FU_LOAD  = 3'd6,
        FU_STORE = 3'd7
    } fu_sel_e;

    typedef struct packed {
        logic [31:0]    pc;
        logic [31:0]    inst;
        logic [31:0]    imm;
        logic [4:0]     op;
        logic [2:0]     f3;
        logic [6:0]     f7;
        logic [PW-1:0]  P_rs1;
        logic [PW-1:0]  P_rs2;
        logic [PW-1:0]  P_rd;
        logic [2:0]     fu_sel;
        logic [RW-1:0]  rob_idx;
        logic [LQW-1:0] lq_tail;
        logic [SQW-1:0] sq_tail;
        logic           jump;
    } iss_bundle_t;

    typedef struct packed {
        logic        valid;
        logic        r1;
        logic        r2;
        iss_bundle_t uop;
    } iq_entry_t;

    function automatic logic uses_rs1(input logic [4:0] op);
        return !(op == LUI || op == AUIPC || op == JAL);
    endfunction

    function automatic logic uses_rs2(input logic [4:0] op);
        return op == R_TYPE || op == F_TYPE || op == S_TYPE || op == FSTORE || op == B_TYPE;
    endfunction

endpackage

// File: rtl/iq_select.sv
// Oldest-first picker: reduces the candidate vector to the slot with the smallest age.
// Purely combinational binary tree; ages are assumed unique among candidates.
module iq_select #(
    parameter int N  = 16,
    parameter int AW = 5
) (
    input  logic [N-1:0]         cand,
    input  logic [N-1:0][AW-1:0] age,
    output logic                 grant_vld,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic [N-1:0]         grant_oh
);
    localparam int IW = $clog2(N);

    // Heap-ordered tree: leaves at [N, 2N), root at 1, node 0 unused.
    logic          node_vld [2*N];
    logic [AW-1:0] node_age [2*N];
    logic [IW-1:0] node_idx [2*N];

    always_comb begin
        node_vld[0] = 1'b0;
        node_age[0] = '0;
        node_idx[0] = '0;
        for (int i = 0; i < N; i++) begin
            node_vld[N+i] = cand[i];
            node_age[N+i] = age[i];
            node_idx[N+i] = IW'(i);
        end
        for (int k = N - 1; k >= 1; k--) begin
            if (node_vld[2*k] && (!node_vld[2*k+1] || node_age[2*k] <= node_age[2*k+1])) begin
                node_vld[k] = 1'b1;
                node_age[k] = node_age[2*k];
                node_idx[k] = node_idx[2*k];
            end else begin
                node_vld[k] = node_vld[2*k+1];
                node_age[k] = node_age[2*k+1];
                node_idx[k] = node_idx[2*k+1];
            end
        end
        grant_vld = node_vld[1];
        grant_idx = node_idx[1];
        grant_oh  = '0;
        grant_oh[grant_idx] = node_vld[1];
    end

endmodule

// File: rtl/issue_queue.sv
// Issue queue: buffers renamed uops, wakes sources from the CDB, issues the oldest ready uop per cycle.
// One registered issue per cycle; IS_ready drops only when every slot is occupied.
module issue_queue
    import ooo_pkg::*;
#(
    parameter int IQ_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DC_valid,
    input  logic [31:0]       DC_out_pc,
    input  logic [31:0]       DC_out_inst,
    input  logic [31:0]       DC_out_imm,
    input  logic [4:0]        DC_out_op,
    input  logic [2:0]        DC_out_f3,
    input  logic [6:0]        DC_out_f7,
    input  logic [PW-1:0]     DC_out_P_rs1,
    input  logic [PW-1:0]     DC_out_P_rs2,
    input  logic [PW-1:0]     DC_out_P_rd,
    input  logic [2:0]        DC_out_fu_sel,
    input  logic [RW-1:0]     DC_out_rob_idx,
    input  logic [LQW-1:0]    DC_out_LQ_tail,
    input  logic [SQW-1:0]    DC_out_SQ_tail,
    input  logic              DC_out_jump,
    input  logic              rs1_rdy_in,
    input  logic              rs2_rdy_in,
    output logic              IS_ready,
    input  logic [1:0]        cdb_valid,
    input  logic [1:0][PW-1:0] cdb_P_rd,
    input  logic [7:0]        fu_ready,
    input  logic [RW-1:0]     rob_head,
    input  logic              mispredict,
    input  logic [RW-1:0]     flush_rob_idx,
    input  logic              stall,
    output logic              iss_valid,
    output logic [31:0]       iss_pc,
    output logic [31:0]       iss_inst,
    output logic [31:0]       iss_imm,
    output logic [4:0]        iss_op,
    output logic [2:0]        iss_f3,
    output logic [6:0]        iss_f7,
    output logic [PW-1:0]     iss_P_rs1,
    output logic [PW-1:0]     iss_P_rs2,
    output logic [PW-1:0]     iss_P_rd,
    output logic [2:0]        iss_fu_sel,
    output logic [RW-1:0]     iss_rob_idx,
    output logic [LQW-1:0]    iss_LQ_tail,
    output logic [SQW-1:0]    iss_SQ_tail,
    output logic              iss_jump
);
    localparam int IW = $clog2(IQ_LEN);

    iq_entry_t   slot_q [IQ_LEN];
    iss_bundle_t iss_q;
    logic        iss_valid_q;

    iss_bundle_t               dc_uop;
    iq_entry_t                 new_entry;
    logic [IQ_LEN-1:0]         valid_vec;
    logic [IQ_LEN-1:0]         wake1;
    logic [IQ_LEN-1:0]         wake2;
    logic [IQ_LEN-1:0]         cand;
    logic [IQ_LEN-1:0]         kill;
    logic [IQ_LEN-1:0][RW-1:0] age;
    logic [RW-1:0]             flush_age;
    logic [IW-1:0]             free_idx;
    logic                      alloc;
    logic                      grant_vld;
    logic [IW-1:0]             grant_idx;
    logic [IQ_LEN-1:0]         grant_oh;
    logic                      do_issue;

    // Tag 0 is the hardwired-ready register and never produces a wakeup.
    function automatic logic tag_hit(input logic [PW-1:0] tag, input logic [1:0] v,
                                     input logic [1:0][PW-1:0] t);
        return (tag != '0) && ((v[0] && t[0] == tag) || (v[1] && t[1] == tag));
    endfunction

    always_comb begin
        dc_uop = '{pc:      DC_out_pc,
                   inst:    DC_out_inst,
                   imm:     DC_out_imm,
                   op:      DC_out_op,
                   f3:      DC_out_f3,
                   f7:      DC_out_f7,
                   P_rs1:   DC_out_P_rs1,
                   P_rs2:   DC_out_P_rs2,
                   P_rd:    DC_out_P_rd,
                   fu_sel:  DC_out_fu_sel,
                   rob_idx: DC_out_rob_idx,
                   lq_tail: DC_out_LQ_tail,
                   sq_tail: DC_out_SQ_tail,
                   jump:    DC_out_jump};
        new_entry.valid = 1'b1;
        new_entry.r1    = rs1_rdy_in || !uses_rs1(DC_out_op) || DC_out_P_rs1 == '0 ||
                          tag_hit(DC_out_P_rs1, cdb_valid, cdb_P_rd);
        new_entry.r2    = rs2_rdy_in || !uses_rs2(DC_out_op) || DC_out_P_rs2 == '0 ||
                          tag_hit(DC_out_P_rs2, cdb_valid, cdb_P_rd);
        new_entry.uop   = dc_uop;
    end

    // Ages are relative to the ROB head so that rob_idx wrap-around orders correctly.
    assign flush_age = flush_rob_idx - rob_head;

    always_comb begin
        for (int i = 0; i < IQ_LEN; i++) begin
            valid_vec[i] = slot_q[i].valid;
            age[i]       = slot_q[i].uop.rob_idx - rob_head;
            wake1[i]     = slot_q[i].valid && tag_hit(slot_q[i].uop.P_rs1, cdb_valid, cdb_P_rd);
            wake2[i]     = slot_q[i].valid && tag_hit(slot_q[i].uop.P_rs2, cdb_valid, cdb_P_rd);
            cand[i]      = slot_q[i].valid && slot_q[i].r1 && slot_q[i].r2 &&
                           fu_ready[slot_q[i].uop.fu_sel];
            kill[i]      = age[i] > flush_age;
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = IQ_LEN - 1; i >= 0; i--) begin
            if (!slot_q[i].valid) free_idx = IW'(i);
        end
    end

    assign IS_ready = ~&valid_vec;
    assign alloc    = DC_valid && !mispredict && IS_ready;
    assign do_issue = grant_vld && !stall && !mispredict;

    iq_select #(
        .N  (IQ_LEN),
        .AW (RW)
    ) u_select (
        .cand      (cand),
        .age       (age),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .grant_oh  (grant_oh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < IQ_LEN; i++) slot_q[i] <= '0;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
        end else begin
            for (int i = 0; i < IQ_LEN; i++) begin
                if (alloc && free_idx == IW'(i)) begin
                    slot_q[i] <= new_entry;
                end else begin
                    if (wake1[i]) slot_q[i].r1 <= 1'b1;
                    if (wake2[i]) slot_q[i].r2 <= 1'b1;
                    if ((do_issue && grant_oh[i]) || (mispredict && kill[i]))
                        slot_q[i].valid <= 1'b0;
                end
            end
            iss_valid_q <= do_issue;
            if (do_issue) iss_q <= slot_q[grant_idx].uop;
        end
    end

    // Dispatch must already be gated by IS_ready upstream.
    assert property (@(posedge clk) disable iff (rst) !(DC_valid && !IS_ready));

    assign iss_valid   = iss_valid_q;
    assign iss_pc      = iss_q.pc;
    assign iss_inst    = iss_q.inst;
    assign iss_imm     = iss_q.imm;
    assign iss_op      = iss_q.op;
    assign iss_f3      = iss_q.f3;
    assign iss_f7      = iss_q.f7;
    assign iss_P_rs1   = iss_q.P_rs1;
    assign iss_P_rs2   = iss_q.P_rs2;
    assign iss_P_rd    = iss_q.P_rd;
    assign iss_fu_sel  = iss_q.fu_sel;
    assign iss_rob_idx = iss_q.rob_idx;
    assign iss_LQ_tail = iss_q.lq_tail;
    assign iss_SQ_tail = iss_q.sq_tail;
    assign iss_jump    = iss_q.jump;

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_issue_queue;
    import ooo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             dc_valid;
    iss_bundle_t      dc;
    logic             rs1_rdy, rs2_rdy;
    logic             IS_ready;
    logic [1:0]       cdb_valid;
    logic [1:0][6:0]  cdb_tag;
    logic [7:0]       fu_ready;
    logic [4:0]       rob_head;
    logic             mispredict;
    logic [4:0]       flush_idx;
    logic             stall;
    logic             iss_valid;
    logic [31:0]      iss_pc, iss_inst, iss_imm;
    logic [4:0]       iss_op;
    logic [2:0]       iss_f3;
    logic [6:0]       iss_f7;
    logic [6:0]       iss_P_rs1, iss_P_rs2, iss_P_rd;
    logic [2:0]       iss_fu_sel;
    logic [4:0]       iss_rob_idx;
    logic [4:0]       iss_LQ_tail, iss_SQ_tail;
    logic             iss_jump;
    iss_bundle_t      iss_b;

    issue_queue #(.IQ_LEN(16)) dut (
        .clk(clk), .rst(rst), .DC_valid(dc_valid),
        .DC_out_pc(dc.pc), .DC_out_inst(dc.inst), .DC_out_imm(dc.imm), .DC_out_op(dc.op),
        .DC_out_f3(dc.f3), .DC_out_f7(dc.f7), .DC_out_P_rs1(dc.P_rs1), .DC_out_P_rs2(dc.P_rs2),
        .DC_out_P_rd(dc.P_rd), .DC_out_fu_sel(dc.fu_sel), .DC_out_rob_idx(dc.rob_idx),
        .DC_out_LQ_tail(dc.lq_tail), .DC_out_SQ_tail(dc.sq_tail), .DC_out_jump(dc.jump),
        .rs1_rdy_in(rs1_rdy), .rs2_rdy_in(rs2_rdy), .IS_ready(IS_ready),
        .cdb_valid(cdb_valid), .cdb_P_rd(cdb_tag), .fu_ready(fu_ready), .rob_head(rob_head),
        .mispredict(mispredict), .flush_rob_idx(flush_idx), .stall(stall),
        .iss_valid(iss_valid), .iss_pc(iss_pc), .iss_inst(iss_inst), .iss_imm(iss_imm),
        .iss_op(iss_op), .iss_f3(iss_f3), .iss_f7(iss_f7), .iss_P_rs1(iss_P_rs1),
        .iss_P_rs2(iss_P_rs2), .iss_P_rd(iss_P_rd), .iss_fu_sel(iss_fu_sel),
        .iss_rob_idx(iss_rob_idx), .iss_LQ_tail(iss_LQ_tail), .iss_SQ_tail(iss_SQ_tail),
        .iss_jump(iss_jump)
    );

    assign iss_b = {iss_pc, iss_inst, iss_imm, iss_op, iss_f3, iss_f7, iss_P_rs1, iss_P_rs2,
                    iss_P_rd, iss_fu_sel, iss_rob_idx, iss_LQ_tail, iss_SQ_tail, iss_jump};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        iss_bundle_t u;
        logic        r1;
        logic        r2;
    } mentry_t;
    typedef struct {
        int          stamp;
        iss_bundle_t u;
    } exp_t;

    mentry_t model[$];
    exp_t    expq[$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference rules, written from the opcode table
    function automatic bit m_use1(input logic [4:0] op);
        return !(op == 5'b01101 || op == 5'b00101 || op == 5'b11011);
    endfunction
    function automatic bit m_use2(input logic [4:0] op);
        return op == 5'b01100 || op == 5'b10100 || op == 5'b01000 || op == 5'b01001 || op == 5'b11000;
    endfunction
    function automatic bit m_hit(input logic [6:0] tag);
        return tag != 0 && ((cdb_valid[0] && cdb_tag[0] == tag) || (cdb_valid[1] && cdb_tag[1] == tag));
    endfunction
    function automatic int m_age(input logic [4:0] r);
        return (int'(r) - int'(rob_head) + 32) % 32;
    endfunction

    // Apply the currently driven inputs for one clock edge to the model, then advance to the next negedge.
    task automatic step();
        int best;
        check("is_ready", IS_ready, model.size() < 16);
        if (rst) begin
            model.delete();
        end else begin
            best = -1;
            if (!stall && !mispredict) begin
                for (int j = 0; j < model.size(); j++) begin
                    if (model[j].r1 && model[j].r2 && fu_ready[model[j].u.fu_sel] &&
                        (best < 0 || m_age(model[j].u.rob_idx) < m_age(model[best].u.rob_idx)))
                        best = j;
                end
            end
            if (best >= 0) begin
                exp_t e;
                e.stamp = cyc + 1;
                e.u = model[best].u;
                expq.push_back(e);
                model.delete(best);
            end
            if (mispredict) begin
                for (int j = model.size() - 1; j >= 0; j--)
                    if (m_age(model[j].u.rob_idx) > m_age(flush_idx)) model.delete(j);
            end
            for (int j = 0; j < model.size(); j++) begin
                if (m_hit(model[j].u.P_rs1)) model[j].r1 = 1'b1;
                if (m_hit(model[j].u.P_rs2)) model[j].r2 = 1'b1;
            end
            if (dc_valid && !mispredict) begin
                mentry_t m;
                m.u  = dc;
                m.r1 = rs1_rdy || !m_use1(dc.op) || dc.P_rs1 == 0 || m_hit(dc.P_rs1);
                m.r2 = rs2_rdy || !m_use2(dc.op) || dc.P_rs2 == 0 || m_hit(dc.P_rs2);
                model.push_back(m);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        dc_valid = 0; cdb_valid = 0; mispredict = 0; stall = 0; rst = 0;
        fu_ready = 8'hFF; rs1_rdy = 0; rs2_rdy = 0;
    endtask

    task automatic set_uop(input logic [4:0] op, input logic [2:0] fu, input logic [4:0] rob,
                           input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] rd);
        dc_valid   = 1;
        dc.pc      = $urandom;
        dc.inst    = $urandom;
        dc.imm     = $urandom;
        dc.op      = op;
        dc.f3      = 3'($urandom);
        dc.f7      = 7'($urandom);
        dc.P_rs1   = s1;
        dc.P_rs2   = s2;
        dc.P_rd    = rd;
        dc.fu_sel  = fu;
        dc.rob_idx = rob;
        dc.lq_tail = 5'($urandom);
        dc.sq_tail = 5'($urandom);
        dc.jump    = 1'($urandom);
    endtask

    task automatic idle_steps(input int n);
        idle();
        for (int k = 0; k < n; k++) step();
    endtask

    // Scoreboard monitor: every issue must match the oldest outstanding expectation, on its cycle.
    always @(negedge clk) begin
        if (iss_valid === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_issue_rob", iss_rob_idx, 160'h1_0000);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("issue_cycle", cyc, e.stamp);
                check("issue_bundle", iss_b, e.u);
            end
        end
    end

    logic [4:0] ops [11] = '{5'b01100, 5'b10100, 5'b01000, 5'b01001, 5'b11000, 5'b01101,
                             5'b00101, 5'b11011, 5'b11001, 5'b00000, 5'b00100};

    initial begin
        int next_rob;
        bit taken;
        dc = '0; cdb_tag = '0; rob_head = 0; flush_idx = 0;
        idle();
        rst = 1;
        @(negedge clk); @(negedge clk);
        rst = 0;
        check("rst_iss_valid", iss_valid, 0);
        check("rst_iss_bundle", iss_b, 0);
        check("rst_is_ready", IS_ready, 1);

        // T1: ready ADD issues on the following cycle
        set_uop(5'b01100, FU_ALU, 5'd3, 7'd5, 7'd6, 7'd20); rs1_rdy = 1; rs2_rdy = 1;
        step();
        idle_steps(3);

        // T2: pending source, woken by CDB; issue only one cycle after the broadcast
        set_uop(5'b01100, FU_ALU, 5'd4, 7'd40, 7'd6, 7'd21); rs2_rdy = 1;
        step();
        idle_steps(2);
        cdb_valid = 2'b01; cdb_tag[0] = 7'd40;
        step();
        idle_steps(3);

        // T3: wrapped ROB index is younger than 31 when head is 30
        rob_head = 5'd30;
        set_uop(5'b01100, FU_ALU, 5'd1, 7'd0, 7'd0, 7'd22); rs1_rdy = 1; rs2_rdy = 1; stall = 1;
        step();
        set_uop(5'b01100, FU_ALU, 5'd31, 7'd0, 7'd0, 7'd23); rs1_rdy = 1; rs2_rdy = 1; stall = 1;
        step();
        idle_steps(4);

        // T4: fill with unready MULs, block the MUL unit, then drain one per cycle
        rob_head = 5'd0;
        for (int k = 0; k < 16; k++) begin
            idle();
            set_uop(5'b01100, FU_MUL, 5'(k), 7'd60, 7'd61, 7'(70 + k)); rs2_rdy = 1;
            step();
        end
        idle_steps(1);
        idle(); fu_ready = 8'hFD; cdb_valid = 2'b10; cdb_tag[1] = 7'd60;
        step();
        idle(); fu_ready = 8'hFD;
        step(); step();
        idle_steps(18);

        // T5: flush removes strictly younger entries only
        set_uop(5'b01100, FU_ALU, 5'd2, 7'd0, 7'd0, 7'd30); rs1_rdy = 1; rs2_rdy = 1; stall = 1;
        step();
        set_uop(5'b11000, FU_BR, 5'd5, 7'd0, 7'd0, 7'd0); rs1_rdy = 1; rs2_rdy = 1; stall = 1;
        step();
        set_uop(5'b01100, FU_ALU, 5'd9, 7'd0, 7'd0, 7'd31); rs1_rdy = 1; rs2_rdy = 1; stall = 1;
        step();
        idle(); mispredict = 1; flush_idx = 5'd5;
        step();
        idle_steps(4);

        // T6: wakeup coincident with dispatch captured at allocation
        set_uop(5'b01100, FU_ALU, 5'd10, 7'd55, 7'd0, 7'd32);
        cdb_valid = 2'b01; cdb_tag[0] = 7'd55;
        step();
        idle_steps(3);

        // Random traffic, with one reset in the middle
        next_rob = 0;
        for (int c = 0; c < 1500; c++) begin
            idle();
            rob_head  = 5'($urandom);
            stall     = ($urandom_range(0, 9) == 0);
            mispredict = ($urandom_range(0, 19) == 0);
            flush_idx = 5'($urandom);
            fu_ready  = 8'($urandom) | 8'($urandom) | 8'($urandom);
            cdb_valid = 2'($urandom);
            cdb_tag[0] = 7'($urandom_range(0, 12));
            cdb_tag[1] = 7'($urandom_range(0, 12));
            if (model.size() < 16 && $urandom_range(0, 2) != 0) begin
                do begin
                    taken = 0;
                    next_rob = (next_rob + 1) % 32;
                    for (int j = 0; j < model.size(); j++)
                        if (int'(model[j].u.rob_idx) == next_rob) taken = 1;
                end while (taken);
                set_uop(ops[$urandom_range(0, 10)], 3'($urandom), 5'(next_rob),
                        7'($urandom_range(0, 12)), 7'($urandom_range(0, 12)), 7'($urandom));
                rs1_rdy = ($urandom_range(0, 1) == 1);
                rs2_rdy = ($urandom_range(0, 1) == 1);
            end
            rst = (c == 800);
            step();
            if (c == 800) begin
                check("midrst_iss_valid", iss_valid, 0);
                check("midrst_iss_bundle", iss_b, 0);
            end
        end
        idle_steps(5);
        check("scoreboard_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
